// File: rtl/usb_desc_pkg.sv
// Shared constants for the EP0 descriptor engine: descriptor type codes,
// FSM state encoding and the fixed language-ID string length.
package usb_desc_pkg;

    localparam logic [7:0] DESC_DEV    = 8'h01;
    localparam logic [7:0] DESC_CFG    = 8'h02;
    localparam logic [7:0] DESC_STR    = 8'h03;
    localparam logic [7:0] DESC_QUAL   = 8'h06;
    localparam logic [7:0] DESC_OSCFG  = 8'h07;
    localparam logic [7:0] DESC_BOS    = 8'h0F;
    localparam logic [7:0] DESC_HIDRPT = 8'h22;

    localparam logic [15:0] STRLANG_LEN = 16'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_SEND,
        S_WAIT_ACK,
        S_DONE,
        S_STALL
    } state_t;

    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_desc_lookup.sv
// Combinational decode of descriptor type/index/speed into ROM start address,
// length, stall and other-speed substitution flag. USB_DESC_HID_EN enables 0x22.
import usb_desc_pkg::*;

module usb_desc_lookup (
    input  logic [7:0]  req_type,
    input  logic [7:0]  req_index,
    input  logic        hs,
    input  logic        have_strings,
    input  logic [15:0] dev_addr,
    input  logic [15:0] dev_len,
    input  logic [15:0] qual_addr,
    input  logic [15:0] qual_len,
    input  logic [15:0] fscfg_addr,
    input  logic [15:0] fscfg_len,
    input  logic [15:0] hscfg_addr,
    input  logic [15:0] hscfg_len,
    input  logic [15:0] hidrpt_addr,
    input  logic [15:0] hidrpt_len,
    input  logic [15:0] bos_addr,
    input  logic [15:0] bos_len,
    input  logic [15:0] strlang_addr,
    input  logic [15:0] strvendor_addr,
    input  logic [15:0] strvendor_len,
    input  logic [15:0] strproduct_addr,
    input  logic [15:0] strproduct_len,
    input  logic [15:0] strserial_addr,
    input  logic [15:0] strserial_len,
    output logic [15:0] addr,
    output logic [15:0] len,
    output logic        stall,
    output logic        os_subst
);

`ifndef USB_DESC_HID_EN
    logic unused_hid;
    assign unused_hid = ^{hidrpt_addr, hidrpt_len};
`endif

    always_comb begin
        addr     = '0;
        len      = '0;
        stall    = 1'b0;
        os_subst = 1'b0;
        case (req_type)
            DESC_DEV:  begin addr = dev_addr;  len = dev_len;  end
            DESC_QUAL: begin addr = qual_addr; len = qual_len; end
            DESC_BOS:  begin addr = bos_addr;  len = bos_len;  end
            DESC_CFG: begin
                addr = hs ? hscfg_addr : fscfg_addr;
                len  = hs ? hscfg_len  : fscfg_len;
            end
            // other-speed config is the opposite-speed config with its type byte patched
            DESC_OSCFG: begin
                addr     = hs ? fscfg_addr : hscfg_addr;
                len      = hs ? fscfg_len  : hscfg_len;
                os_subst = 1'b1;
            end
            DESC_STR: begin
                if (!have_strings) begin
                    stall = 1'b1;
                end else begin
                    case (req_index)
                        8'd0:    begin addr = strlang_addr;    len = STRLANG_LEN;    end
                        8'd1:    begin addr = strvendor_addr;  len = strvendor_len;  end
                        8'd2:    begin addr = strproduct_addr; len = strproduct_len; end
                        8'd3:    begin addr = strserial_addr;  len = strserial_len;  end
                        default: stall = 1'b1;
                    endcase
                end
            end
`ifdef USB_DESC_HID_EN
            DESC_HIDRPT: begin addr = hidrpt_addr; len = hidrpt_len; end
`else
            DESC_HIDRPT: stall = 1'b1;
`endif
            default: stall = 1'b1;
        endcase
        if (req_type != DESC_STR && req_index != 8'd0) begin
            stall = 1'b1;
        end
    end

endmodule

// File: rtl/usb_desc_reader.sv
// EP0 GET_DESCRIPTOR engine: looks up a descriptor, streams it from ROM in
// MPS-sized packets with ACK/retry and ZLP handling. USB_DESC_HID_EN enables HID reports.
import usb_desc_pkg::*;

module usb_desc_reader #(
    parameter int EP0_MPS_FS = 8,
    parameter int EP0_MPS_HS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic [7:0]  req_type_i,
    input  logic [7:0]  req_index_i,
    input  logic [15:0] req_wlength_i,
    input  logic        hs_mode_i,
    output logic [15:0] descrom_raddr_o,
    input  logic [7:0]  descrom_rdata_i,
    input  logic [15:0] desc_dev_addr_i,
    input  logic [15:0] desc_dev_len_i,
    input  logic [15:0] desc_qual_addr_i,
    input  logic [15:0] desc_qual_len_i,
    input  logic [15:0] desc_fscfg_addr_i,
    input  logic [15:0] desc_fscfg_len_i,
    input  logic [15:0] desc_hscfg_addr_i,
    input  logic [15:0] desc_hscfg_len_i,
    input  logic [15:0] desc_hidrpt_addr_i,
    input  logic [15:0] desc_hidrpt_len_i,
    input  logic [15:0] desc_bos_addr_i,
    input  logic [15:0] desc_bos_len_i,
    input  logic [15:0] desc_strvendor_addr_i,
    input  logic [15:0] desc_strvendor_len_i,
    input  logic [15:0] desc_strproduct_addr_i,
    input  logic [15:0] desc_strproduct_len_i,
    input  logic [15:0] desc_strserial_addr_i,
    input  logic [15:0] desc_strserial_len_i,
    input  logic [15:0] desc_oscfg_addr_i,
    input  logic [15:0] desc_strlang_addr_i,
    input  logic        desc_have_strings_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_last_o,
    output logic        tx_zlp_o,
    input  logic        tx_ready_i,
    input  logic        pkt_ack_i,
    input  logic        pkt_retry_i,
    output logic        stall_o,
    output logic        done_o
);

    localparam logic [15:0] MPS_FS = 16'(EP0_MPS_FS);
    localparam logic [15:0] MPS_HS = 16'(EP0_MPS_HS);

    state_t      state, state_nxt;
    logic [7:0]  req_type, req_index;
    logic [15:0] req_wlength, base_addr, xfer_len, offset, pkt_start;
    logic        hs, os_subst, zlp_req, zlp_sent;

    logic [15:0] lk_addr, lk_len, lk_xfer_len, mps;
    logic        lk_stall, lk_os;
    logic        pkt_last, more_bytes, need_zlp;

    usb_desc_lookup u_lookup (
        .req_type        (req_type),
        .req_index       (req_index),
        .hs              (hs),
        .have_strings    (desc_have_strings_i),
        .dev_addr        (desc_dev_addr_i),
        .dev_len         (desc_dev_len_i),
        .qual_addr       (desc_qual_addr_i),
        .qual_len        (desc_qual_len_i),
        .fscfg_addr      (desc_fscfg_addr_i),
        .fscfg_len       (desc_fscfg_len_i),
        .hscfg_addr      (desc_hscfg_addr_i),
        .hscfg_len       (desc_hscfg_len_i),
        .hidrpt_addr     (desc_hidrpt_addr_i),
        .hidrpt_len      (desc_hidrpt_len_i),
        .bos_addr        (desc_bos_addr_i),
        .bos_len         (desc_bos_len_i),
        .strlang_addr    (desc_strlang_addr_i),
        .strvendor_addr  (desc_strvendor_addr_i),
        .strvendor_len   (desc_strvendor_len_i),
        .strproduct_addr (desc_strproduct_addr_i),
        .strproduct_len  (desc_strproduct_len_i),
        .strserial_addr  (desc_strserial_addr_i),
        .strserial_len   (desc_strserial_len_i),
        .addr            (lk_addr),
        .len             (lk_len),
        .stall           (lk_stall),
        .os_subst        (lk_os)
    );

    // Offset 1 of an other-speed config reads the patched type byte instead.
    function automatic logic [15:0] rom_addr(input logic [15:0] off, input logic [15:0] base,
                                             input logic subst, input logic [15:0] os_addr);
        return (subst && off == 16'd1) ? os_addr : base + off;
    endfunction

    assign mps         = hs ? MPS_HS : MPS_FS;
    assign lk_xfer_len = min16(lk_len, req_wlength);
    assign pkt_last    = (offset + 16'd1 == xfer_len) || (offset - pkt_start + 16'd1 == mps);
    assign more_bytes  = offset != xfer_len;
    assign need_zlp    = (xfer_len < req_wlength) &&
                         ((hs ? (xfer_len % MPS_HS) : (xfer_len % MPS_FS)) == 16'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (req_valid_i) begin
            state_nxt = S_LOOKUP;
        end else begin
            case (state)
                S_LOOKUP: begin
                    if (lk_stall)                 state_nxt = S_STALL;
                    else if (lk_xfer_len == 16'd0) state_nxt = S_DONE;
                    else                          state_nxt = S_SEND;
                end
                S_SEND: if (tx_ready_i && pkt_last) state_nxt = S_WAIT_ACK;
                S_WAIT_ACK: begin
                    if (!zlp_req) begin
                        if (pkt_retry_i) begin
                            if (!zlp_sent) state_nxt = S_SEND;
                        end else if (pkt_ack_i) begin
                            if (more_bytes)                    state_nxt = S_SEND;
                            else if (!(need_zlp && !zlp_sent)) state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_valid_o = (state == S_SEND);
        tx_data_o  = tx_valid_o ? descrom_rdata_i : 8'h00;
        tx_last_o  = tx_valid_o && pkt_last;
        tx_zlp_o   = (state == S_WAIT_ACK) && zlp_req;
        stall_o    = (state == S_STALL);
        done_o     = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_type        <= '0;
            req_index       <= '0;
            req_wlength     <= '0;
            hs              <= 1'b0;
            base_addr       <= '0;
            xfer_len        <= '0;
            offset          <= '0;
            pkt_start       <= '0;
            os_subst        <= 1'b0;
            zlp_req         <= 1'b0;
            zlp_sent        <= 1'b0;
            descrom_raddr_o <= '0;
        end else if (req_valid_i) begin
            req_type    <= req_type_i;
            req_index   <= req_index_i;
            req_wlength <= req_wlength_i;
            hs          <= hs_mode_i;
            zlp_req     <= 1'b0;
            zlp_sent    <= 1'b0;
        end else begin
            case (state)
                S_LOOKUP: begin
                    base_addr       <= lk_addr;
                    xfer_len        <= lk_xfer_len;
                    os_subst        <= lk_os;
                    offset          <= '0;
                    pkt_start       <= '0;
                    descrom_raddr_o <= lk_addr;
                end
                S_SEND: begin
                    if (tx_ready_i) begin
                        offset          <= offset + 16'd1;
                        descrom_raddr_o <= rom_addr(offset + 16'd1, base_addr, os_subst,
                                                    desc_oscfg_addr_i);
                    end
                end
                S_WAIT_ACK: begin
                    if (zlp_req) begin
                        if (tx_ready_i) begin
                            zlp_req  <= 1'b0;
                            zlp_sent <= 1'b1;
                        end
                    end else if (pkt_retry_i) begin
                        if (zlp_sent) begin
                            zlp_req <= 1'b1;
                        end else begin
                            offset          <= pkt_start;
                            descrom_raddr_o <= rom_addr(pkt_start, base_addr, os_subst,
                                                        desc_oscfg_addr_i);
                        end
                    end else if (pkt_ack_i) begin
                        if (more_bytes)                 pkt_start <= offset;
                        else if (need_zlp && !zlp_sent) zlp_req   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
